sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, meaning the CPU byte address that maps to SRAM word 0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port wr_en, input, 1, MEM-stage store request.
REQ-005 SHALL have port rd_en, input, 1, MEM-stage load request.
REQ-006 SHALL have port address, input, 32, CPU byte address, word-aligned.
REQ-007 SHALL have port write_data, input, 32, store data.
REQ-008 SHALL have port read_data, output, 32, registered load data.
REQ-009 SHALL have port ready, output, 1, low means freeze the pipeline.
REQ-010 SHALL have port SRAM_DQ, inout, 16, SRAM data bus.
REQ-011 SHALL have port SRAM_ADDR, output, 18, SRAM halfword address.
REQ-012 SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N and SRAM_OE_N, each output, 1, SRAM strobes, active-low.

Function
REQ-013 SHALL implement FSM states IDLE, A1, A2, A3 and DONE.
REQ-014 SHALL, in IDLE with (wr_en | rd_en) = 1, latch address, write_data and op (write if wr_en, else read), then go to A1.
REQ-015 SHALL otherwise remain in IDLE.
REQ-016 SHALL sequence A1 -> A2 -> A3 -> DONE -> IDLE unconditionally.
REQ-017 SHALL give write priority when wr_en and rd_en are both 1 on acceptance.
REQ-018 SHALL compute eff = latched_address - BASE_ADDR modulo 2^32.
REQ-019 SHALL use lo = {eff[18:2], 1'b0} and hi = {eff[18:2], 1'b1}; bits eff[31:19] and eff[1:0] are ignored.
REQ-020 SHALL drive SRAM_ADDR = lo in A1 and = hi in A2 and A3.
REQ-021 SHALL drive SRAM_ADDR = 0 in IDLE and DONE.
REQ-022 SHALL, for a write, drive SRAM_WE_N = 0 in A1 and A2 and 1 in every other state.
REQ-023 SHALL, for a write, drive SRAM_DQ = write_data[15:0] in A1 and write_data[31:16] in A2.
REQ-024 SHALL hold SRAM_DQ at high-Z in all other states and for every read.
REQ-025 SHALL, for a read, keep SRAM_WE_N = 1 throughout.
REQ-026 SHALL, for a read, capture SRAM_DQ into read_data[15:0] at the end of A2 and into read_data[31:16] at the end of A3.
REQ-027 SHALL keep read_data unchanged by writes and hold its value until the next read completes.
REQ-028 SHALL tie SRAM_UB_N, SRAM_LB_N, SRAM_CE_N and SRAM_OE_N to 0.
REQ-029 SHALL make ready combinational: 1 in IDLE when wr_en = rd_en = 0, 0 in IDLE when a request is present, 0 in A1-A3, 1 in DONE.
REQ-030 SHALL give a fixed 5-cycle access: the request cycle plus A1-A3 have ready = 0, and DONE has ready = 1 with read_data valid.
REQ-031 SHALL ignore request input changes after acceptance until the FSM returns to IDLE.
REQ-032 SHALL, when a request is present in the IDLE cycle right after DONE, treat it as a new access.

Reset
REQ-033 SHALL, when rst = 1 at a clock edge, force state to IDLE, read_data to 0 and latched address, data and op to 0.
REQ-034 SHALL show these output values on the cycle after reset: SRAM_WE_N = 1, SRAM_DQ high-Z, SRAM_ADDR = 0, and ready = ~(wr_en | rd_en).
REQ-035 SHALL, on reset mid-access, abort the access, perform no further SRAM writes and leave read_data = 0.
REQ-036 SHALL give rst priority over any request in the same cycle.

Verification
REQ-037 SHALL cover write then read-back: write address 1024, data 32'hDEADBEEF -> SRAM word0 = BEEF and word1 = DEAD; a read of 1024 gives read_data = 32'hDEADBEEF in DONE, with ready low for exactly 4 cycles each access.
REQ-038 SHALL cover address mapping: write address 1036, data 32'h12345678 -> SRAM_ADDR = 6 in A1 and 7 in A2, words 6 and 7 = 5678 and 1234.
REQ-039 SHALL cover simultaneous requests: wr_en = rd_en = 1, address 1028, data 32'hA5A5_0F0F -> write performed, read_data unchanged, words 2 and 3 written.
REQ-040 SHALL cover back-to-back accesses: read 1024 held through DONE, then a read of 1028 in the next cycle -> two complete 5-cycle accesses, no lost or merged access.
REQ-041 SHALL cover reset mid-write: rst = 1 in A1 of a write to 1040 -> word 9 unmodified, SRAM_WE_N = 1 next cycle, state IDLE, read_data = 0.
REQ-042 SHALL cover idle behaviour: no requests for 10 cycles -> ready = 1, SRAM_WE_N = 1, SRAM_DQ high-Z, read_data stable.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges a 32-bit single-cycle MEM stage to a 16-bit synchronous SRAM.
// Each access takes five cycles, and ready stalls the pipeline until DONE.
module sram_controller #(
   parameter logic [31:0] BASE_ADDR = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_A1   = 3'd1,
      S_A2   = 3'd2,
      S_A3   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        op_wr_q;
   logic [31:0] rdata_q;

   logic        accept;
   logic [31:0] eff;
   logic [16:0] word_idx;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        unused_eff_bits;

   assign accept          = (state_q == S_IDLE) && (wr_en || rd_en);
   assign eff             = addr_q - BASE_ADDR;
   assign word_idx        = eff[18:2];
   assign unused_eff_bits = ^{eff[31:19], eff[1:0]};

   // State and datapath registers; the SRAM has one cycle of read latency,
   // so each halfword is captured one state after its address is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         op_wr_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= address;
            wdata_q <= write_data;
            op_wr_q <= wr_en;
         end
         if (state_q == S_A2 && !op_wr_q) rdata_q[15:0]  <= SRAM_DQ;
         if (state_q == S_A3 && !op_wr_q) rdata_q[31:16] <= SRAM_DQ;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (wr_en || rd_en) state_d = S_A1;
         S_A1:    state_d = S_A2;
         S_A2:    state_d = S_A3;
         S_A3:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = wdata_q[15:0];
      ready     = 1'b0;
      case (state_q)
         S_IDLE: ready = !(wr_en || rd_en);
         S_A1: begin
            SRAM_ADDR = {word_idx, 1'b0};
            SRAM_WE_N = !op_wr_q;
            dq_oe     = op_wr_q;
            dq_out    = wdata_q[15:0];
         end
         S_A2: begin
            SRAM_ADDR = {word_idx, 1'b1};
            SRAM_WE_N = !op_wr_q;
            dq_oe     = op_wr_q;
            dq_out    = wdata_q[31:16];
         end
         S_A3:    SRAM_ADDR = {word_idx, 1'b1};
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign SRAM_DQ     = dq_oe ? dq_out : 16'hzzzz;
   assign read_data   = rdata_q;
   assign SRAM_UB_N   = 1'b0;
   assign SRAM_LB_N   = 1'b0;
   assign SRAM_CE_N   = 1'b0;
   assign SRAM_OE_N   = 1'b0;
   assign dbg_state_o = state_q;

endmodule
